instruction_fetch: RTL

Instruction fetch stage sitting directly downstream of `program_counter`. Consumes the current PC, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and buffers them in a 2-entry queue for decode under valid/ready. Generates the program counter's clock enable, so the PC only advances once a fetch for the current address has been issued, or when a redirect must be loaded. Discards queued and in-flight instructions on a branch/jump flush.

---
 rtl/instruction_fetch_if.sv | 21 ++
 rtl/instruction_fetch.sv | 113 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus bundle: imem req/ack read port and the decode valid/ready port.
interface instruction_fetch_if;
  logic        imem_req_po;
  logic [15:0] imem_addr_po;
  logic        imem_ack_pi;
  logic [15:0] imem_data_pi;
  logic        instr_valid_po;
  logic [15:0] instr_po;
  logic [15:0] instr_pc_po;
  logic        instr_ready_pi;

  modport master (
    output imem_req_po, imem_addr_po, instr_valid_po, instr_po, instr_pc_po,
    input  imem_ack_pi, imem_data_pi, instr_ready_pi
  );

  modport slave (
    input  imem_req_po, imem_addr_po, instr_valid_po, instr_po, instr_pc_po,
    output imem_ack_pi, imem_data_pi, instr_ready_pi
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one imem read at a time for the current PC, buffers results in a
// 2-entry queue for decode, and gates the PC clock enable on issue or redirect.
module instruction_fetch (
  input  logic                clk_pi,
  input  logic                reset_pi,
  input  logic [15:0]         pc_pi,
  input  logic                flush_pi,
  output logic                pc_clk_en_po,
  instruction_fetch_if.master fetch_if
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q [2];
  logic [15:0] ipc_q   [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        issue, push, pop, tail;

  always_comb begin
    issue = (state_q == StIdle) && !flush_pi && (count_q != 2'd2);
    push  = (state_q == StWait) && fetch_if.imem_ack_pi && !flush_pi;
    pop   = (count_q != 2'd0) && fetch_if.instr_ready_pi && !flush_pi;
    tail  = head_q ^ count_q[0];
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StWait;
          req_d   = 1'b1;
          addr_d  = pc_pi;
        end
      end
      StWait: begin
        if (fetch_if.imem_ack_pi) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (flush_pi) begin
          // Requests are never withdrawn; wait out the ack and discard it.
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (fetch_if.imem_ack_pi) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (flush_pi) begin
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      head_d = head_q ^ pop;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= 16'h0000;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      instr_q[0] <= 16'h0000;
      instr_q[1] <= 16'h0000;
      ipc_q[0]   <= 16'h0000;
      ipc_q[1]   <= 16'h0000;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      count_q <= count_d;
      if (push) begin
        instr_q[tail] <= fetch_if.imem_data_pi;
        ipc_q[tail]   <= addr_q;
      end
    end
  end

  assign pc_clk_en_po            = !reset_pi && (flush_pi || issue);
  assign fetch_if.imem_req_po    = req_q;
  assign fetch_if.imem_addr_po   = addr_q;
  assign fetch_if.instr_valid_po = (count_q != 2'd0);
  assign fetch_if.instr_po       = instr_q[head_q];
  assign fetch_if.instr_pc_po    = ipc_q[head_q];

endmodule
